// File: rtl/inj_pkg.sv
// Shared definitions for the injection sequencer: FSM states, LFSR polynomial,
// and the bit positions of the target stimulus and response buses.
package inj_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [7:0] LFSR_MASK = 8'hB8;

    localparam int IN_A = 5;
    localparam int IN_B = 4;
    localparam int IN_C = 3;
    localparam int IN_D = 2;
    localparam int IN_E = 1;
    localparam int IN_F = 0;

    localparam int Y_1 = 1;
    localparam int Y_2 = 0;

    // One step of the right-shifting Galois LFSR for x^8+x^6+x^5+x^4+1.
    function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
        logic [7:0] shifted;
        shifted = {1'b0, cur[7:1]};
        return cur[0] ? (shifted ^ LFSR_MASK) : shifted;
    endfunction

endpackage

// File: rtl/injection_golden_model.sv
// Reference model of the injection target: two sticky/gated flags that the
// sequencer compares against the real target's response one cycle later.
module injection_golden_model
    import inj_pkg::*;
(
    input  logic       clk,
    input  logic       clear,
    input  logic       enable,
    input  logic [5:0] stim,
    output logic [1:0] y
);

    logic g1;
    logic g2;

    always_ff @(posedge clk) begin
        if (clear) begin
            g1 <= 1'b0;
            g2 <= 1'b0;
        end else if (enable) begin
            g1 <= (g1 | stim[IN_A] | stim[IN_B]) & stim[IN_C];
            g2 <= (g2 | ~stim[IN_D]) & (stim[IN_E] | ~stim[IN_F]);
        end
    end

    always_comb begin
        y      = '0;
        y[Y_1] = g1;
        y[Y_2] = g2;
    end

endmodule

// File: rtl/injection_sequencer.sv
// Drives an LFSR vector stream into a target under test, checks its response
// against a golden model with one cycle of latency, and reports mismatches.
module injection_sequencer
    import inj_pkg::*;
#(
    parameter int W_CNT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       seed,
    input  logic [7:0]       n_vec,
    output logic             dut_rstn,
    output logic [5:0]       dut_in,
    input  logic [1:0]       dut_y,
    output logic             busy,
    output logic             done,
    output logic [W_CNT-1:0] err_cnt,
    output logic [7:0]       first_err_idx,
    output logic             pass
);

    state_t     state;
    state_t     state_next;
    logic [7:0] lfsr;
    logic [7:0] idx;
    logic [7:0] last_idx;
    logic [7:0] cmp_idx;
    logic [1:0] gold_y;
    logic       run_en;
    logic       compare_en;
    logic       mismatch;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_INIT;
            ST_INIT:  state_next = ST_RUN;
            ST_RUN:   if (idx == last_idx) state_next = ST_DRAIN;
            ST_DRAIN: state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Vector i's response arrives in the cycle after it is applied, so the
    // first RUN cycle has nothing to compare and DRAIN checks the last one.
    assign run_en     = (state == ST_RUN);
    assign compare_en = (run_en && (idx != 8'd0)) || (state == ST_DRAIN);
    assign mismatch   = compare_en && (dut_y != gold_y);

    // last_idx wraps n_vec=0 to 255, giving a 256-vector run.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr     <= 8'h01;
            idx      <= 8'd0;
            last_idx <= 8'd0;
            cmp_idx  <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        lfsr     <= (seed == 8'h00) ? 8'h01 : seed;
                        last_idx <= n_vec - 8'd1;
                    end
                end
                ST_INIT: begin
                    idx     <= 8'd0;
                    cmp_idx <= 8'd0;
                end
                ST_RUN: begin
                    lfsr    <= lfsr_next(lfsr);
                    cmp_idx <= idx;
                    if (idx != last_idx) begin
                        idx <= idx + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // A saturated counter never returns to zero, so err_cnt==0 marks the first miss.
    always_ff @(posedge clk) begin
        if (rst || (state == ST_INIT)) begin
            err_cnt       <= '0;
            first_err_idx <= 8'd0;
        end else if (mismatch) begin
            if (err_cnt != {W_CNT{1'b1}}) begin
                err_cnt <= err_cnt + W_CNT'(1);
            end
            if (err_cnt == '0) begin
                first_err_idx <= cmp_idx;
            end
        end
    end

    injection_golden_model u_golden (
        .clk    (clk),
        .clear  (rst || (state == ST_INIT)),
        .enable (run_en),
        .stim   (dut_in),
        .y      (gold_y)
    );

    assign dut_rstn = ~(rst || (state == ST_INIT));
    assign dut_in   = run_en ? lfsr[5:0] : 6'd0;
    assign busy     = (state == ST_INIT) || (state == ST_RUN) || (state == ST_DRAIN);
    assign done     = (state == ST_DONE);
    assign pass     = (err_cnt == '0);

endmodule

// File: tb/tb_injection_sequencer.sv
// Scoreboard bench for injection_sequencer: stimulus pushes expected run
// results and vectors, a monitor pops and compares on each done pulse.
module tb_injection_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic [7:0] seed;
    logic [7:0] n_vec;
    logic       dut_rstn;
    logic [5:0] dut_in;
    logic [1:0] dut_y;
    logic       busy;
    logic       done;
    logic [7:0] err_cnt;
    logic [7:0] first_err_idx;
    logic       pass;

    logic       start_b;
    logic [7:0] seed_b;
    logic [7:0] n_vec_b;
    logic       dut_rstn_b;
    logic [5:0] dut_in_b;
    logic [1:0] dut_y_b;
    logic       busy_b;
    logic       done_b;
    logic [3:0] err_cnt_b;
    logic [7:0] first_err_idx_b;
    logic       pass_b;

    injection_sequencer #(.W_CNT(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed), .n_vec(n_vec),
        .dut_rstn(dut_rstn), .dut_in(dut_in), .dut_y(dut_y), .busy(busy),
        .done(done), .err_cnt(err_cnt), .first_err_idx(first_err_idx), .pass(pass)
    );

    injection_sequencer #(.W_CNT(4)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .seed(seed_b), .n_vec(n_vec_b),
        .dut_rstn(dut_rstn_b), .dut_in(dut_in_b), .dut_y(dut_y_b), .busy(busy_b),
        .done(done_b), .err_cnt(err_cnt_b), .first_err_idx(first_err_idx_b), .pass(pass_b)
    );

    // Behavioural targets: 0 = correct, 1 = y1 stuck at 1, 2 = both outputs inverted.
    int   target_mode = 0;
    logic t1, t2, t1b, t2b;

    always @(posedge clk) begin
        if (!dut_rstn) begin
            t1 <= 1'b0;
            t2 <= 1'b0;
        end else begin
            t1 <= (t1 | dut_in[5] | dut_in[4]) & dut_in[3];
            t2 <= (t2 | ~dut_in[2]) & (dut_in[1] | ~dut_in[0]);
        end
        if (!dut_rstn_b) begin
            t1b <= 1'b0;
            t2b <= 1'b0;
        end else begin
            t1b <= (t1b | dut_in_b[5] | dut_in_b[4]) & dut_in_b[3];
            t2b <= (t2b | ~dut_in_b[2]) & (dut_in_b[1] | ~dut_in_b[0]);
        end
    end

    assign dut_y   = (target_mode == 1) ? {1'b1, t2} :
                     (target_mode == 2) ? ~{t1, t2} : {t1, t2};
    assign dut_y_b = ~{t1b, t2b};

    int total_checks = 0;
    int bad_checks   = 0;

    typedef struct {
        int n;
        int err;
        int first;
        int pass;
        int busy;
    } exp_t;

    exp_t       exp_q[$];
    logic [5:0] vec_q[$];
    exp_t       last_exp;

    // First 16 dut_in values for seed 0x01, worked out by hand.
    logic [5:0] hand_vec [16] = '{6'h01, 6'h38, 6'h1C, 6'h2E, 6'h17, 6'h33, 6'h21, 6'h08,
                                  6'h24, 6'h32, 6'h19, 6'h34, 6'h1A, 6'h2D, 6'h2E, 6'h17};

    task automatic checkOutput(input string name, input int actual, input int expected);
        total_checks++;
        if (actual != expected) begin
            bad_checks++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        logic [7:0] s;
        s = {1'b0, l[7:1]};
        return l[0] ? (s ^ 8'hB8) : s;
    endfunction

    task automatic model_run(input logic [7:0] sd, input int n, input int mode, input int sat,
                             input bit push_vec, output exp_t e);
        logic [7:0] l;
        logic       g1, g2;
        logic [5:0] v;
        logic [1:0] y;
        int         err_n, first_n;
        l = (sd == 8'h00) ? 8'h01 : sd;
        g1 = 1'b0;
        g2 = 1'b0;
        err_n = 0;
        first_n = 0;
        for (int i = 0; i < n; i++) begin
            v = l[5:0];
            if (push_vec) vec_q.push_back(v);
            g1 = (g1 | v[5] | v[4]) & v[3];
            g2 = (g2 | ~v[2]) & (v[1] | ~v[0]);
            case (mode)
                1:       y = {1'b1, g2};
                2:       y = ~{g1, g2};
                default: y = {g1, g2};
            endcase
            if (y != {g1, g2}) begin
                if (err_n == 0) first_n = i;
                if (err_n < sat) err_n++;
            end
            l = lfsr_step(l);
        end
        e.n     = n;
        e.err   = err_n;
        e.first = first_n;
        e.pass  = (err_n == 0) ? 1 : 0;
        e.busy  = n + 2;
    endtask

    task automatic applyStimulus(input logic [7:0] sd, input logic [7:0] nv, input int mode,
                                 input bit hand);
        exp_t e;
        int   n;
        bit   seen;
        n = (nv == 8'd0) ? 256 : int'(nv);
        target_mode = mode;
        model_run(sd, n, mode, 255, !hand, e);
        if (hand) begin
            for (int i = 0; i < 16; i++) vec_q.push_back(hand_vec[i]);
        end
        exp_q.push_back(e);
        last_exp = e;
        @(posedge clk); #1;
        start = 1'b1;
        seed  = sd;
        n_vec = nv;
        @(posedge clk); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < n + 10 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checkOutput("done_timeout", int'(seen), 1);
        repeat (2) @(posedge clk);
    endtask

    // Monitor for instance A: vector stream, busy length and results per done.
    int   run_left   = 0;
    int   vec_bad    = 0;
    int   busy_len   = 0;
    int   zero_seen  = 0;
    exp_t mon_e;
    logic [5:0] want_vec;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                run_left  = 0;
                busy_len  = 0;
                zero_seen = 0;
            end else begin
                if (busy) busy_len++;
                if (busy && u_dut.lfsr == 8'h00) zero_seen++;
                if (run_left > 0) begin
                    if (vec_q.size() == 0) begin
                        vec_bad++;
                    end else begin
                        want_vec = vec_q.pop_front();
                        if (dut_in != want_vec) vec_bad++;
                    end
                    run_left--;
                end else if (busy && !dut_rstn && exp_q.size() > 0) begin
                    run_left = exp_q[0].n;
                    vec_bad  = 0;
                end
                if (done) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_done", int'(done), 0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        checkOutput("err_cnt", int'(err_cnt), mon_e.err);
                        checkOutput("first_err_idx", int'(first_err_idx), mon_e.first);
                        checkOutput("pass", int'(pass), mon_e.pass);
                        checkOutput("busy_cycles", busy_len, mon_e.busy);
                        checkOutput("vector_errors", vec_bad, 0);
                        checkOutput("lfsr_zero_cycles", zero_seen, 0);
                    end
                    busy_len  = 0;
                    zero_seen = 0;
                end
            end
        end
    end

    initial begin
        exp_t       e;
        int         dones;
        int         busy_cnt;
        bit         seen;
        logic [7:0] l;

        rst = 1'b1;
        start = 1'b0;
        seed = 8'h00;
        n_vec = 8'd0;
        start_b = 1'b0;
        seed_b = 8'h00;
        n_vec_b = 8'd0;

        @(negedge clk);
        checkOutput("rst_dut_rstn", int'(dut_rstn), 0);
        checkOutput("rst_dut_rstn_b", int'(dut_rstn_b), 0);
        @(negedge clk);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_err_cnt", int'(err_cnt), 0);
        checkOutput("rst_first_err_idx", int'(first_err_idx), 0);
        checkOutput("rst_pass", int'(pass), 1);
        checkOutput("rst_dut_in", int'(dut_in), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_dut_rstn", int'(dut_rstn), 1);

        $display("[TB] correct target, seed 0x01 and seed 0x00, 16 vectors");
        applyStimulus(8'h01, 8'd16, 0, 1'b1);
        applyStimulus(8'h00, 8'd16, 0, 1'b1);

        $display("[TB] y1 stuck at 1, 32 vectors");
        applyStimulus(8'h2E, 8'd32, 1, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("hold_err_cnt", int'(err_cnt), last_exp.err);
        checkOutput("hold_first_err_idx", int'(first_err_idx), last_exp.first);
        checkOutput("hold_pass", int'(pass), 0);

        $display("[TB] n_vec=0 gives 256 vectors");
        applyStimulus(8'h5A, 8'd0, 0, 1'b0);

        $display("[TB] start held high across two runs");
        target_mode = 0;
        model_run(8'h55, 3, 0, 255, 1'b1, e);
        exp_q.push_back(e);
        model_run(8'h55, 3, 0, 255, 1'b1, e);
        exp_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b1;
        seed  = 8'h55;
        n_vec = 8'd3;
        dones = 0;
        for (int k = 0; k < 60 && dones < 2; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        start = 1'b0;
        checkOutput("held_start_runs", dones, 2);
        repeat (5) @(negedge clk);
        checkOutput("held_start_idle", int'(busy), 0);

        $display("[TB] reset during RUN vector 5");
        target_mode = 0;
        @(posedge clk); #1;
        start = 1'b1;
        seed  = 8'h33;
        n_vec = 8'd32;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        l = 8'h33;
        repeat (5) l = lfsr_step(l);
        checkOutput("abort_busy_before", int'(busy), 1);
        checkOutput("abort_vector5", int'(dut_in), int'(l[5:0]));
        rst = 1'b1;
        #1;
        checkOutput("abort_dut_rstn", int'(dut_rstn), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_err_cnt", int'(err_cnt), 0);
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) dones++;
        end
        checkOutput("abort_no_done", dones, 0);

        $display("[TB] W_CNT=4, inverted target, 256 vectors");
        @(posedge clk); #1;
        start_b = 1'b1;
        seed_b  = 8'h01;
        n_vec_b = 8'd0;
        @(posedge clk); #1;
        start_b = 1'b0;
        busy_cnt = 0;
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            if (busy_b) busy_cnt++;
            if (done_b) seen = 1'b1;
        end
        checkOutput("b_done_timeout", int'(seen), 1);
        checkOutput("b_busy_cycles", busy_cnt, 258);
        checkOutput("b_err_cnt", int'(err_cnt_b), 15);
        checkOutput("b_first_err_idx", int'(first_err_idx_b), 0);
        checkOutput("b_pass", int'(pass_b), 0);

        repeat (4) @(negedge clk);
        checkOutput("scoreboard_left", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
